// File: rtl/vcache_perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vcache_perf_pkg
//  Purpose  : Shared event ids, FSM states and sizing helper for the vcache
//             performance-counter bank.
//  Revision : 1.0
// ============================================================================
package vcache_perf_pkg;

  localparam int num_perf_events_gp = 5;

  typedef enum logic [2:0] {
    e_ld       = 3'd0,
    e_st       = 3'd1,
    e_ld_miss  = 3'd2,
    e_st_miss  = 3'd3,
    e_miss_cyc = 3'd4
  } vcache_perf_event_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } vcache_perf_state_e;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcache_perf_ctr_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : vcache_perf_ctr_bank_if
//  Purpose  : Valid/yumi record stream from the counter bank to a stats sink.
//  Revision : 1.0
// ============================================================================
interface vcache_perf_ctr_bank_if
  import vcache_perf_pkg::*;
#(
  parameter int num_banks_p = 1,
  parameter int ctr_width_p = 32,
  parameter int tag_width_p = 32
);

  localparam int c_bank_width = safe_clog2(num_banks_p);

  logic                    stat_v_o;
  logic                    stat_yumi_i;
  logic [c_bank_width-1:0] stat_bank_o;
  logic [2:0]              stat_event_o;
  logic [ctr_width_p-1:0]  stat_count_o;
  logic                    stat_sat_o;
  logic [tag_width_p-1:0]  stat_tag_o;
  logic [31:0]             stat_gctr_o;

  modport master (
    output stat_v_o, stat_bank_o, stat_event_o, stat_count_o,
           stat_sat_o, stat_tag_o, stat_gctr_o,
    input  stat_yumi_i
  );

  modport slave (
    input  stat_v_o, stat_bank_o, stat_event_o, stat_count_o,
           stat_sat_o, stat_tag_o, stat_gctr_o,
    output stat_yumi_i
  );

endinterface
`default_nettype wire

// File: rtl/vcache_perf_sat_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : vcache_perf_sat_ctr
//  Purpose  : Saturating event counter with clear-load and sticky sat flag.
//  Revision : 1.0
// ============================================================================
module vcache_perf_sat_ctr #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [width_p-1:0] count_o,
  output logic               sat_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               sat_q, sat_d;

  // Sat marks a lost event: an increment arriving while already all-ones.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear_i) begin
      count_d = {{(width_p-1){1'b0}}, inc_i};
      sat_d   = 1'b0;
    end else if (inc_i) begin
      if (&count_q) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule
`default_nettype wire

// File: rtl/vcache_perf_ctr_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vcache_perf_ctr_bank
//  Purpose  : Per-bank vcache event counters with snapshot and record dump.
//  Revision : 1.0
// ============================================================================
module vcache_perf_ctr_bank
  import vcache_perf_pkg::*;
#(
  parameter int num_banks_p     = 1,
  parameter int ctr_width_p     = 32,
  parameter int tag_width_p     = 32,
  parameter bit clear_on_snap_p = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_banks_p-1:0] resp_v_i,
  input  logic [num_banks_p-1:0] resp_ld_i,
  input  logic [num_banks_p-1:0] resp_st_i,
  input  logic [num_banks_p-1:0] resp_miss_i,
  input  logic [num_banks_p-1:0] miss_busy_i,
  input  logic [31:0]            global_ctr_i,
  input  logic                   print_stat_v_i,
  input  logic [tag_width_p-1:0] print_stat_tag_i,
  output logic                   busy_o,
  output logic [15:0]            drop_cnt_o,
  vcache_perf_ctr_bank_if.master stat_if
);

  localparam int c_bank_width = safe_clog2(num_banks_p);
  localparam int c_num_ctrs   = num_banks_p * num_perf_events_gp;
  localparam int c_idx_width  = safe_clog2(c_num_ctrs);
  localparam logic [c_bank_width-1:0] c_last_bank = c_bank_width'(num_banks_p - 1);

  vcache_perf_state_e      state_q, state_d;
  logic [c_bank_width-1:0] bank_q, bank_d;
  logic [2:0]              event_q, event_d;
  logic [c_idx_width-1:0]  idx_q, idx_d;
  logic [15:0]             drop_q, drop_d;
  logic [tag_width_p-1:0]  tag_q;
  logic [31:0]             gctr_q;
  logic [ctr_width_p-1:0]  shadow_cnt_q [c_num_ctrs];
  logic [c_num_ctrs-1:0]   shadow_sat_q;

  logic [c_num_ctrs-1:0]   w_inc;
  logic [c_num_ctrs-1:0]   w_live_sat;
  logic [ctr_width_p-1:0]  w_live_cnt [c_num_ctrs];
  logic                    w_snap;
  logic                    w_clear;
  logic                    w_dump;
  logic                    w_last_rec;

  assign w_dump     = (state_q == DUMP);
  assign w_snap     = (state_q == IDLE) & print_stat_v_i;
  assign w_clear    = w_snap & clear_on_snap_p;
  assign w_last_rec = (event_q == e_miss_cyc) && (bank_q == c_last_bank);

  // Counters are laid out bank-major so the dump index is a plain increment.
  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    assign w_inc[b*num_perf_events_gp + int'(e_ld)]      = resp_v_i[b] & resp_ld_i[b];
    assign w_inc[b*num_perf_events_gp + int'(e_st)]      = resp_v_i[b] & resp_st_i[b];
    assign w_inc[b*num_perf_events_gp + int'(e_ld_miss)] = resp_v_i[b] & resp_ld_i[b] & resp_miss_i[b];
    assign w_inc[b*num_perf_events_gp + int'(e_st_miss)] = resp_v_i[b] & resp_st_i[b] & resp_miss_i[b];
    assign w_inc[b*num_perf_events_gp + int'(e_miss_cyc)] = miss_busy_i[b] & ~resp_v_i[b];

    for (genvar e = 0; e < num_perf_events_gp; e++) begin : g_evt
      vcache_perf_sat_ctr #(
        .width_p (ctr_width_p)
      ) u_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (w_inc[b*num_perf_events_gp + e]),
        .clear_i (w_clear),
        .count_o (w_live_cnt[b*num_perf_events_gp + e]),
        .sat_o   (w_live_sat[b*num_perf_events_gp + e])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    event_d = event_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (print_stat_v_i) begin
          state_d = DUMP;
          bank_d  = '0;
          event_d = '0;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (print_stat_v_i && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
        if (stat_if.stat_yumi_i) begin
          if (w_last_rec) begin
            state_d = IDLE;
            bank_d  = '0;
            event_d = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + c_idx_width'(1);
            if (event_q == e_miss_cyc) begin
              event_d = '0;
              bank_d  = bank_q + c_bank_width'(1);
            end else begin
              event_d = event_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      event_q      <= '0;
      idx_q        <= '0;
      drop_q       <= '0;
      tag_q        <= '0;
      gctr_q       <= '0;
      shadow_sat_q <= '0;
      for (int i = 0; i < c_num_ctrs; i++) begin
        shadow_cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      event_q <= event_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      if (w_snap) begin
        tag_q        <= print_stat_tag_i;
        gctr_q       <= global_ctr_i;
        shadow_sat_q <= w_live_sat;
        for (int i = 0; i < c_num_ctrs; i++) begin
          shadow_cnt_q[i] <= w_live_cnt[i];
        end
      end
    end
  end

  assign busy_o               = w_dump;
  assign drop_cnt_o           = drop_q;
  assign stat_if.stat_v_o     = w_dump;
  assign stat_if.stat_bank_o  = bank_q;
  assign stat_if.stat_event_o = event_q;
  assign stat_if.stat_count_o = w_dump ? shadow_cnt_q[idx_q] : '0;
  assign stat_if.stat_sat_o   = w_dump & shadow_sat_q[idx_q];
  assign stat_if.stat_tag_o   = w_dump ? tag_q : '0;
  assign stat_if.stat_gctr_o  = w_dump ? gctr_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_vcache_perf_ctr_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vcache_perf_ctr_bank
//  Purpose  : Bench driving two counter-bank configurations in lockstep
//             against an event-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_vcache_perf_ctr_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v, ld, st, miss, mbz;
  logic        pstat;
  logic [31:0] tag, gctr;
  logic        ya, yb;
  logic        busy_a, busy_b;
  logic [15:0] drop_a, drop_b;

  always #5 clk = ~clk;

  vcache_perf_ctr_bank_if #(.num_banks_p(4), .ctr_width_p(32), .tag_width_p(32)) ifa ();
  vcache_perf_ctr_bank_if #(.num_banks_p(2), .ctr_width_p(4),  .tag_width_p(8))  ifb ();
  assign ifa.stat_yumi_i = ya;
  assign ifb.stat_yumi_i = yb;

  vcache_perf_ctr_bank #(
    .num_banks_p(4), .ctr_width_p(32), .tag_width_p(32), .clear_on_snap_p(1'b0)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .resp_v_i(v), .resp_ld_i(ld), .resp_st_i(st),
    .resp_miss_i(miss), .miss_busy_i(mbz), .global_ctr_i(gctr),
    .print_stat_v_i(pstat), .print_stat_tag_i(tag),
    .busy_o(busy_a), .drop_cnt_o(drop_a), .stat_if(ifa)
  );

  vcache_perf_ctr_bank #(
    .num_banks_p(2), .ctr_width_p(4), .tag_width_p(8), .clear_on_snap_p(1'b1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .resp_v_i(v[1:0]), .resp_ld_i(ld[1:0]), .resp_st_i(st[1:0]),
    .resp_miss_i(miss[1:0]), .miss_busy_i(mbz[1:0]), .global_ctr_i(gctr),
    .print_stat_v_i(pstat), .print_stat_tag_i(tag[7:0]),
    .busy_o(busy_b), .drop_cnt_o(drop_b), .stat_if(ifb)
  );

  // Reference model: event tallies per (dut, bank, event) plus a list of expected records.
  int           nb [2];
  longint       maxv [2];
  bit           clr [2];
  longint       cnt [2][4][5];
  bit           sat [2][4][5];
  bit           mbusy [2];
  int           rd_ptr [2];
  int           n_rec [2];
  int           drops [2];
  logic [119:0] exp_rec [2][20];
  longint       obs_cnt [2][4][5];
  bit           obs_sat [2][4][5];
  logic [31:0]  obs_tag [2];
  logic [31:0]  obs_gctr [2];
  logic [31:0]  snap_g;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string name, input logic [119:0] got, input logic [119:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [119:0] rec_a();
    return {8'(ifa.stat_bank_o), 8'(ifa.stat_event_o), ifa.stat_count_o, 7'd0,
            ifa.stat_sat_o, ifa.stat_tag_o, ifa.stat_gctr_o};
  endfunction

  function automatic logic [119:0] rec_b();
    return {8'(ifb.stat_bank_o), 8'(ifb.stat_event_o), 28'd0, ifb.stat_count_o, 7'd0,
            ifb.stat_sat_o, 24'd0, ifb.stat_tag_o, ifb.stat_gctr_o};
  endfunction

  task automatic model_step();
    bit y [2];
    bit was_busy;
    bit accept;
    bit inc [5];
    logic [31:0] tg;
    y[0] = ya;
    y[1] = yb;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int b = 0; b < 4; b++)
          for (int e = 0; e < 5; e++) begin
            cnt[d][b][e] = 0;
            sat[d][b][e] = 1'b0;
          end
        mbusy[d] = 1'b0; rd_ptr[d] = 0; n_rec[d] = 0; drops[d] = 0;
      end else begin
        was_busy = mbusy[d];
        accept   = !was_busy && pstat;
        if (was_busy && pstat && drops[d] < 65535) drops[d]++;
        if (was_busy && y[d]) begin
          rd_ptr[d]++;
          if (rd_ptr[d] == n_rec[d]) mbusy[d] = 1'b0;
        end
        if (accept) begin
          tg = (d == 0) ? tag : {24'd0, tag[7:0]};
          n_rec[d] = 5 * nb[d]; rd_ptr[d] = 0; mbusy[d] = 1'b1;
          for (int b = 0; b < nb[d]; b++)
            for (int e = 0; e < 5; e++)
              exp_rec[d][b*5+e] = {8'(b), 8'(e), 32'(cnt[d][b][e]), 7'd0, sat[d][b][e], tg, gctr};
        end
        for (int b = 0; b < nb[d]; b++) begin
          inc[0] = v[b] & ld[b];
          inc[1] = v[b] & st[b];
          inc[2] = v[b] & ld[b] & miss[b];
          inc[3] = v[b] & st[b] & miss[b];
          inc[4] = mbz[b] & ~v[b];
          for (int e = 0; e < 5; e++) begin
            if (accept && clr[d]) begin
              cnt[d][b][e] = inc[e] ? 1 : 0;
              sat[d][b][e] = 1'b0;
            end else if (inc[e]) begin
              if (cnt[d][b][e] == maxv[d]) sat[d][b][e] = 1'b1;
              else cnt[d][b][e] = cnt[d][b][e] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [119:0] got [2];
    int b, e;
    got[0] = rec_a();
    got[1] = rec_b();
    chk("v_a",    120'(ifa.stat_v_o), 120'(mbusy[0]));
    chk("busy_a", 120'(busy_a),       120'(mbusy[0]));
    chk("drop_a", 120'(drop_a),       120'(drops[0]));
    chk("v_b",    120'(ifb.stat_v_o), 120'(mbusy[1]));
    chk("busy_b", 120'(busy_b),       120'(mbusy[1]));
    chk("drop_b", 120'(drop_b),       120'(drops[1]));
    for (int d = 0; d < 2; d++) begin
      if (mbusy[d]) begin
        chk((d == 0) ? "rec_a" : "rec_b", got[d], exp_rec[d][rd_ptr[d]]);
        b = int'(got[d][119:112]);
        e = int'(got[d][111:104]);
        if (b < nb[d] && e < 5) begin
          obs_cnt[d][b][e] = longint'(got[d][103:72]);
          obs_sat[d][b][e] = got[d][64];
        end
        obs_tag[d]  = got[d][63:32];
        obs_gctr[d] = got[d][31:0];
      end
    end
  endtask

  task automatic cycle(input int ma, input int mb);
    ya = mbusy[0] && (ma == 1 || (ma == 2 && $urandom_range(1, 0) == 1));
    yb = mbusy[1] && (mb == 1 || (mb == 2 && $urandom_range(1, 0) == 1));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    gctr = gctr + 32'd1;
  endtask

  task automatic clr_in();
    v = '0; ld = '0; st = '0; miss = '0; mbz = '0; pstat = 1'b0;
  endtask

  task automatic rand_traffic();
    v = 4'($urandom); ld = 4'($urandom); st = 4'($urandom);
    miss = 4'($urandom); mbz = 4'($urandom);
  endtask

  task automatic snap(input logic [31:0] t);
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 4; b++)
        for (int e = 0; e < 5; e++) begin
          obs_cnt[d][b][e] = -1;
          obs_sat[d][b][e] = 1'b0;
        end
    tag = t; pstat = 1'b1; snap_g = gctr;
    cycle(0, 0);
    pstat = 1'b0;
    chk("snap_lat_a", 120'(ifa.stat_v_o), 120'(1));
  endtask

  task automatic run_until_idle(input int ma, input int mb, input bit rnd);
    int n = 0;
    while ((mbusy[0] || mbusy[1]) && n < 400) begin
      if (rnd) rand_traffic();
      cycle(ma, mb);
      n++;
    end
    clr_in();
  endtask

  initial begin
    int guard;
    nb[0] = 4; nb[1] = 2;
    maxv[0] = 64'hFFFF_FFFF; maxv[1] = 15;
    clr[0] = 1'b0; clr[1] = 1'b1;
    rst = 1'b1; clr_in(); tag = '0; gctr = 32'h0000_1000; ya = 1'b0; yb = 1'b0;
    cycle(0, 0);
    cycle(0, 0);
    chk("rst_rec_a", rec_a(), '0);
    chk("rst_rec_b", rec_b(), '0);
    rst = 1'b0;

    // Load hits then store misses on bank 0.
    v = 4'b0001; ld = 4'b0001;
    repeat (3) cycle(0, 0);
    ld = '0; st = 4'b0001; miss = 4'b0001;
    repeat (2) cycle(0, 0);
    clr_in();
    snap(32'h0000_00A5);
    run_until_idle(1, 1, 1'b0);
    chk("t1_ld",      120'(obs_cnt[0][0][0]), 120'(3));
    chk("t1_st",      120'(obs_cnt[0][0][1]), 120'(2));
    chk("t1_ld_miss", 120'(obs_cnt[0][0][2]), 120'(0));
    chk("t1_st_miss", 120'(obs_cnt[0][0][3]), 120'(2));
    chk("t1_tag",     120'(obs_tag[0]),       120'(32'h0000_00A5));
    chk("t1_gctr",    120'(obs_gctr[0]),      120'(snap_g));
    chk("t1_b_ld",    120'(obs_cnt[1][0][0]), 120'(3));

    // Saturation on the narrow bank, then restart after a clearing snapshot.
    v = 4'b0010; ld = 4'b0010;
    repeat (20) cycle(0, 0);
    clr_in();
    snap(32'h0000_005A);
    run_until_idle(1, 1, 1'b0);
    chk("sat_b_cnt", 120'(obs_cnt[1][1][0]), 120'(15));
    chk("sat_b_bit", 120'(obs_sat[1][1][0]), 120'(1));
    chk("sat_a_cnt", 120'(obs_cnt[0][1][0]), 120'(20));
    v = 4'b0010; ld = 4'b0010;
    repeat (2) cycle(0, 0);
    clr_in();
    snap(32'h0000_0033);
    run_until_idle(1, 1, 1'b0);
    chk("clr_b_cnt", 120'(obs_cnt[1][1][0]), 120'(2));
    chk("clr_b_bit", 120'(obs_sat[1][1][0]), 120'(0));
    chk("clr_a_cnt", 120'(obs_cnt[0][1][0]), 120'(22));

    // Miss-handling cycles followed by a load miss.
    mbz = 4'b0001;
    repeat (7) cycle(0, 0);
    v = 4'b0001; ld = 4'b0001; miss = 4'b0001;
    cycle(0, 0);
    clr_in();
    snap(32'h0000_0044);
    run_until_idle(1, 1, 1'b0);
    chk("mc_a_cyc",  120'(obs_cnt[0][0][4]), 120'(7));
    chk("mc_a_ldm",  120'(obs_cnt[0][0][2]), 120'(1));
    chk("mc_b_cyc",  120'(obs_cnt[1][0][4]), 120'(7));
    chk("mc_b_ldm",  120'(obs_cnt[1][0][2]), 120'(1));

    // Random traffic with a randomly stalled consumer.
    repeat (40) begin
      rand_traffic();
      cycle(0, 0);
    end
    clr_in();
    snap($urandom);
    run_until_idle(2, 2, 1'b1);
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 5; e++)
        chk("rnd_seen_a", 120'(obs_cnt[0][b][e] >= 0), 120'(1));

    // Request dropped mid-dump and at the last consume; next-cycle request accepted.
    snap(32'h0000_0077);
    cycle(0, 0);
    pstat = 1'b1;
    cycle(0, 0);
    pstat = 1'b0;
    chk("drop_one", 120'(drop_a), 120'(1));
    guard = 0;
    while (mbusy[0] && guard < 100) begin
      pstat = (rd_ptr[0] == n_rec[0] - 1);
      cycle(1, 1);
      guard++;
    end
    chk("drop_last", 120'(drop_a), 120'(2));
    pstat = 1'b1;
    cycle(1, 1);
    pstat = 1'b0;
    chk("redump_busy", 120'(busy_a), 120'(1));
    run_until_idle(1, 1, 1'b0);

    // Reset in the middle of a dump.
    v = 4'b1111; ld = 4'b1111;
    repeat (3) cycle(0, 0);
    clr_in();
    snap(32'h0000_0011);
    repeat (3) cycle(1, 1);
    rst = 1'b1;
    cycle(0, 0);
    chk("rmid_v",    120'(ifa.stat_v_o), 120'(0));
    chk("rmid_busy", 120'(busy_a),       120'(0));
    chk("rmid_rec",  rec_a(),            '0);
    rst = 1'b0;
    cycle(0, 0);
    snap(32'h0000_0022);
    run_until_idle(1, 1, 1'b0);
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 5; e++)
        chk("rmid_zero", 120'(obs_cnt[0][b][e]), 120'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
